// File: rtl/arb_pkg.sv
// arb_pkg: shared types and constants for the two-master memory arbiter.
//   arb_state_e   : arbiter FSM state (idle / access in flight)
//   arb_owner_e   : which requester owns the access in flight
//   TIMEOUT_RDATA : read data returned when an access is aborted by the watchdog
package arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  typedef enum logic {
    OWN_M0 = 1'b0,
    OWN_M1 = 1'b1
  } arb_owner_e;

  localparam logic [31:0] TIMEOUT_RDATA = 32'hDEADBEEF;

endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: combinational two-way round-robin select.
//   req0, req1  : requests from m0 / m1
//   last_owner  : requester granted most recently (loses a tie)
//   gnt0, gnt1  : one-hot (or zero) selection
module rr_pick2
  import arb_pkg::*;
(
  input  logic       req0,
  input  logic       req1,
  input  arb_owner_e last_owner,
  output logic       gnt0,
  output logic       gnt1
);

  // Lone request wins outright; a tie goes to whoever was not served last.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (req0 && req1) begin
      if (last_owner == OWN_M1) begin
        gnt0 = 1'b1;
      end else begin
        gnt1 = 1'b1;
      end
    end else begin
      gnt0 = req0;
      gnt1 = req1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory/IO port between the core LSU (m0) and the
// debug/loader port (m1). Round-robin, one access in flight, registered
// request towards memory, variable-latency ack, one-cycle rvalid response.
//   clk_i, rst_i          : clock, synchronous active-high reset
//   mX_req/we/addr/wdata/be_i : requester X access (held stable until gnt)
//   mX_gnt_o              : combinational accept in the cycle of the grant
//   mX_rvalid/rdata/err_o : registered response, rdata/err qualified by rvalid
//   core_stall_o          : m0 has a request without a response this cycle
//   mem_req/we/addr/wdata/be_o : registered memory request, held until ack
//   mem_ack_i, mem_rdata_i: memory completion, read data valid with ack
// Build option: define ARB_TIMEOUT_EN to abort accesses that wait TIMEOUT
// BUSY cycles without an ack (err=1, rdata=TIMEOUT_RDATA). Without it the
// arbiter waits indefinitely and the err outputs are tied low.
module mem_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                m0_req_i,
  input  logic                m0_we_i,
  input  logic [ADDR_W-1:0]   m0_addr_i,
  input  logic [DATA_W-1:0]   m0_wdata_i,
  input  logic [DATA_W/8-1:0] m0_be_i,
  output logic                m0_gnt_o,
  output logic                m0_rvalid_o,
  output logic [DATA_W-1:0]   m0_rdata_o,
  output logic                m0_err_o,
  input  logic                m1_req_i,
  input  logic                m1_we_i,
  input  logic [ADDR_W-1:0]   m1_addr_i,
  input  logic [DATA_W-1:0]   m1_wdata_i,
  input  logic [DATA_W/8-1:0] m1_be_i,
  output logic                m1_gnt_o,
  output logic                m1_rvalid_o,
  output logic [DATA_W-1:0]   m1_rdata_o,
  output logic                m1_err_o,
  output logic                core_stall_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic [DATA_W/8-1:0] mem_be_o,
  input  logic                mem_ack_i,
  input  logic [DATA_W-1:0]   mem_rdata_i
);

  localparam int unsigned BE_W = DATA_W / 8;

  if (TIMEOUT == 0) begin : g_bad_timeout
    $error("mem_arbiter: TIMEOUT must be at least 1");
  end

  arb_state_e state_q, state_d;
  arb_owner_e owner_q, last_q, win;

  logic pick0, pick1;
  logic grant;
  logic ack_busy;
  logic tmo_hit;
  logic finish;
  logic [DATA_W-1:0] rsp_data;

  logic              mem_req_q, mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [BE_W-1:0]   mem_be_q;
  logic              m0_rvalid_q, m1_rvalid_q;
  logic [DATA_W-1:0] m0_rdata_q, m1_rdata_q;

  rr_pick2 u_pick (
    .req0       (m0_req_i),
    .req1       (m1_req_i),
    .last_owner (last_q),
    .gnt0       (pick0),
    .gnt1       (pick1)
  );

  assign win      = pick0 ? OWN_M0 : OWN_M1;
  assign ack_busy = (state_q == ARB_BUSY) && mem_ack_i;
  assign finish   = ack_busy || tmo_hit;

  // Watchdog abort returns a marker word; writes always return zero.
  assign rsp_data = tmo_hit  ? DATA_W'(TIMEOUT_RDATA) :
                    mem_we_q ? '0 : mem_rdata_i;

  // State register
  always_ff @(posedge clk_i) begin : state_reg
    if (rst_i) begin
      state_q <= ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state; grant only while no access is in flight
  always_comb begin : state_next
    state_d = state_q;
    grant   = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (pick0 || pick1) begin
          grant   = 1'b1;
          state_d = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        if (finish) begin
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Request capture, owner/pointer tracking and response registers
  always_ff @(posedge clk_i) begin : datapath
    if (rst_i) begin
      owner_q     <= OWN_M0;
      last_q      <= OWN_M1;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
    end else begin
      m0_rvalid_q <= finish && (owner_q == OWN_M0);
      m1_rvalid_q <= finish && (owner_q == OWN_M1);
      if (grant) begin
        owner_q     <= win;
        last_q      <= win;
        mem_req_q   <= 1'b1;
        mem_we_q    <= pick0 ? m0_we_i    : m1_we_i;
        mem_addr_q  <= pick0 ? m0_addr_i  : m1_addr_i;
        mem_wdata_q <= pick0 ? m0_wdata_i : m1_wdata_i;
        mem_be_q    <= pick0 ? m0_be_i    : m1_be_i;
      end
      if (finish) begin
        mem_req_q <= 1'b0;
        if (owner_q == OWN_M0) begin
          m0_rdata_q <= rsp_data;
        end else begin
          m1_rdata_q <= rsp_data;
        end
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] tmo_cnt_q;
  logic             m0_err_q, m1_err_q;

  // Fires on the TIMEOUT-th BUSY cycle without ack; a same-cycle ack wins.
  assign tmo_hit = (state_q == ARB_BUSY) && !mem_ack_i &&
                   (tmo_cnt_q == CNT_W'(TIMEOUT - 1));

  // BUSY cycle counter, cleared on every grant
  always_ff @(posedge clk_i) begin : tmo_count
    if (rst_i || grant) begin
      tmo_cnt_q <= '0;
    end else if ((state_q == ARB_BUSY) && !mem_ack_i) begin
      tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
    end
  end

  // Error flag, updated with the owner's response
  always_ff @(posedge clk_i) begin : err_reg
    if (rst_i) begin
      m0_err_q <= 1'b0;
      m1_err_q <= 1'b0;
    end else if (finish) begin
      if (owner_q == OWN_M0) begin
        m0_err_q <= tmo_hit;
      end else begin
        m1_err_q <= tmo_hit;
      end
    end
  end

  assign m0_err_o = m0_err_q;
  assign m1_err_o = m1_err_q;
`else
  assign tmo_hit  = 1'b0;
  assign m0_err_o = 1'b0;
  assign m1_err_o = 1'b0;
`endif

  assign m0_gnt_o     = grant && pick0;
  assign m1_gnt_o     = grant && pick1;
  assign m0_rvalid_o  = m0_rvalid_q;
  assign m1_rvalid_o  = m1_rvalid_q;
  assign m0_rdata_o   = m0_rdata_q;
  assign m1_rdata_o   = m1_rdata_q;
  assign core_stall_o = m0_req_i && !m0_rvalid_q;
  assign mem_req_o    = mem_req_q;
  assign mem_we_o     = mem_we_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wdata_o  = mem_wdata_q;
  assign mem_be_o     = mem_be_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized + directed bench for mem_arbiter with a
// transaction-level reference model (memory image, round-robin rule, busy
// window) and response scoreboards per requester.
`timescale 1ns/1ps
module tb_mem_arbiter;

  localparam int unsigned TMO = 16;
`ifdef ARB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // requester drive
  logic        drv_req   [2];
  logic        drv_we    [2];
  logic [31:0] drv_addr  [2];
  logic [31:0] drv_wdata [2];
  logic [3:0]  drv_be    [2];

  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err, core_stall;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata_in;
  logic [3:0]  mem_be;

  logic [1:0]  gnt_v, rv_v, err_v;
  logic [31:0] rd_v [2];
  assign gnt_v = {m1_gnt, m0_gnt};
  assign rv_v  = {m1_rvalid, m0_rvalid};
  assign err_v = {m1_err, m0_err};
  assign rd_v[0] = m0_rdata;
  assign rd_v[1] = m1_rdata;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
    .clk_i(clk), .rst_i(rst),
    .m0_req_i(drv_req[0]), .m0_we_i(drv_we[0]), .m0_addr_i(drv_addr[0]),
    .m0_wdata_i(drv_wdata[0]), .m0_be_i(drv_be[0]),
    .m0_gnt_o(m0_gnt), .m0_rvalid_o(m0_rvalid), .m0_rdata_o(m0_rdata), .m0_err_o(m0_err),
    .m1_req_i(drv_req[1]), .m1_we_i(drv_we[1]), .m1_addr_i(drv_addr[1]),
    .m1_wdata_i(drv_wdata[1]), .m1_be_i(drv_be[1]),
    .m1_gnt_o(m1_gnt), .m1_rvalid_o(m1_rvalid), .m1_rdata_o(m1_rdata), .m1_err_o(m1_err),
    .core_stall_o(core_stall),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_be_o(mem_be),
    .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata_in)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return a ^ 32'hC3A5_0F1E;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // ---------------- memory responder (environment) ----------------
  logic [31:0] store [logic [31:0]];
  int lat_cfg  = 0;   // <0: random 0..3 plus stray idle acks; else fixed wait cycles
  bit ack_hold = 1'b0;
  int lat_cnt  = 0;

  always @(posedge clk) begin
    #1;
    mem_ack      = 1'b0;
    mem_rdata_in = $urandom;
    if (mem_req && !ack_hold) begin
      if (lat_cnt == 0) begin
        mem_ack = 1'b1;
        if (mem_we) store[mem_addr] = merge(store.exists(mem_addr) ? store[mem_addr] :
                                            init_val(mem_addr), mem_wdata, mem_be);
        else mem_rdata_in = store.exists(mem_addr) ? store[mem_addr] : init_val(mem_addr);
      end else begin
        lat_cnt--;
      end
    end else if (!mem_req) begin
      lat_cnt = (lat_cfg < 0) ? int'($urandom_range(0, 3)) : lat_cfg;
      mem_ack = (lat_cfg < 0) && ($urandom_range(0, 7) == 0);
    end
  end

  // ---------------- reference model + monitor ----------------
  logic [31:0] ref_mem [logic [31:0]];
  logic [68:0] exp_mem [$];        // {we, addr, wdata, be} of the access in flight
  logic [31:0] exp_rsp0 [$];
  logic [31:0] exp_rsp1 [$];
  bit busy, owner, last, due_tmo;
  bit due [2];
  int tcnt;

  always @(negedge clk) begin
    bit eg0, eg1, fin, ntmo, m;
    bit nd [2];
    logic [31:0] ev, cur;
    if (rst) begin
      busy = 0; owner = 0; last = 1; tcnt = 0; due_tmo = 0;
      due[0] = 0; due[1] = 0;
      exp_mem.delete(); exp_rsp0.delete(); exp_rsp1.delete();
    end else begin
      eg0 = !busy && drv_req[0] && (!drv_req[1] || last == 1'b1);
      eg1 = !busy && drv_req[1] && (!drv_req[0] || last == 1'b0);
      chk("grant", gnt_v, {eg1, eg0});
      chk("mem_req", mem_req, busy);
      if (busy && exp_mem.size() > 0)
        chk("mem_fields", {mem_we, mem_addr, mem_wdata, mem_be}, exp_mem[0]);
      chk("core_stall", core_stall, drv_req[0] && !due[0]);
      for (int i = 0; i < 2; i++) begin
        chk(i == 0 ? "m0_rvalid" : "m1_rvalid", rv_v[i], due[i]);
        if (due[i]) begin
          if (i == 0) ev = (exp_rsp0.size() > 0) ? exp_rsp0.pop_front() : 32'hx;
          else        ev = (exp_rsp1.size() > 0) ? exp_rsp1.pop_front() : 32'hx;
          if (due_tmo) ev = 32'hDEADBEEF;
          if (rv_v[i]) chk(i == 0 ? "m0_rsp" : "m1_rsp", {err_v[i], rd_v[i]}, {due_tmo, ev});
        end
      end
      // advance model to the next cycle
      nd[0] = 0; nd[1] = 0; ntmo = 0; fin = 0;
      if (busy) begin
        if (mem_ack) fin = 1;
        else if (TMO_EN && tcnt == int'(TMO) - 1) begin fin = 1; ntmo = 1; end
        else tcnt++;
        if (fin) begin
          nd[owner] = 1; busy = 0;
          if (exp_mem.size() > 0) void'(exp_mem.pop_front());
        end
      end else if (eg0 || eg1) begin
        m = eg1;
        busy = 1; owner = m; last = m; tcnt = 0;
        exp_mem.push_back({drv_we[m], drv_addr[m], drv_wdata[m], drv_be[m]});
        cur = ref_mem.exists(drv_addr[m]) ? ref_mem[drv_addr[m]] : init_val(drv_addr[m]);
        if (drv_we[m]) ref_mem[drv_addr[m]] = merge(cur, drv_wdata[m], drv_be[m]);
        ev = drv_we[m] ? 32'h0 : cur;
        if (m == 0) exp_rsp0.push_back(ev); else exp_rsp1.push_back(ev);
      end
      due[0] = nd[0]; due[1] = nd[1]; due_tmo = ntmo;
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_txn(input int m, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] b);
    drv_we[m] = w; drv_addr[m] = a; drv_wdata[m] = d; drv_be[m] = b; drv_req[m] = 1'b1;
  endtask

  task automatic rand_txn(input int m);
    set_txn(m, 1'($urandom_range(0, 1)), 32'h1000 + 32'($urandom_range(0, 15)) * 4,
            $urandom, 4'($urandom_range(0, 15)));
  endtask

  task automatic issue(input int m, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] b);
    bit got;
    got = 0;
    @(posedge clk); #1;
    set_txn(m, w, a, d, b);
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      got = gnt_v[m];
    end
    @(posedge clk); #1;
    drv_req[m] = 1'b0;
    chk("grant_wait", got, 1'b1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0]  g;
    logic [15:0] hist;
    int wait_c [2];
    int max_wait;
    rst = 1'b1;
    mem_ack = 1'b0; mem_rdata_in = '0;
    for (int i = 0; i < 2; i++) begin
      drv_req[i] = 0; drv_we[i] = 0; drv_addr[i] = '0; drv_wdata[i] = '0; drv_be[i] = '0;
      wait_c[i] = 0;
    end
    store[32'h100]   = 32'h12345678;
    ref_mem[32'h100] = 32'h12345678;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_outputs", {mem_req, mem_we, mem_addr, mem_wdata, mem_be, rv_v},
        {1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 2'b00});

    // tie right after reset with zero-wait memory: m0, m1, m0, m1 on even cycles
    lat_cfg = 0;
    hist = '0;
    @(posedge clk); #1;
    set_txn(0, 1'b0, 32'h200, 32'h0, 4'hF);
    set_txn(1, 1'b0, 32'h204, 32'h0, 4'hF);
    repeat (8) begin
      @(negedge clk); g = gnt_v; hist = {hist[13:0], g};
      @(posedge clk); #1;
      for (int m = 0; m < 2; m++) if (g[m]) set_txn(m, 1'b0, drv_addr[m] + 32'h8, 32'h0, 4'hF);
    end
    drv_req[0] = 0; drv_req[1] = 0;
    chk("tie_sequence", hist, 16'h4848);
    idle(4);

    // m0 read, memory acks on the third BUSY cycle
    lat_cfg = 2;
    issue(0, 1'b0, 32'h100, 32'h0, 4'hF);
    idle(6);

    // m1 byte write, then read back
    lat_cfg = 1;
    issue(1, 1'b1, 32'h7000, 32'h0000_00A5, 4'b0001);
    issue(1, 1'b0, 32'h7000, 32'h0, 4'hF);
    idle(5);

    // m1 request raised and withdrawn while m0 is in flight
    lat_cfg = 4;
    issue(0, 1'b0, 32'h104, 32'h0, 4'hF);
    set_txn(1, 1'b1, 32'h7004, 32'hFFFF_FFFF, 4'hF);
    idle(2);
    drv_req[1] = 1'b0;
    idle(8);

    // reset while BUSY: access abandoned, next access normal
    ack_hold = 1'b1;
    issue(0, 1'b0, 32'h108, 32'h0, 4'hF);
    idle(2);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    ack_hold = 1'b0;
    lat_cfg = 0;
    idle(3);
    issue(0, 1'b0, 32'h10C, 32'h0, 4'hF);
    idle(4);

`ifdef ARB_TIMEOUT_EN
    ack_hold = 1'b1;
    issue(0, 1'b0, 32'h110, 32'h0, 4'hF);
    idle(22);
    ack_hold = 1'b0;
    lat_cfg = int'(TMO) - 1;
    issue(0, 1'b0, 32'h114, 32'h0, 4'hF);
    idle(22);
`endif

    // random traffic on both ports
    lat_cfg = -1;
    max_wait = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk); g = gnt_v;
      @(posedge clk); #1;
      for (int m = 0; m < 2; m++) begin
        if (drv_req[m]) begin
          if (g[m]) begin
            wait_c[m] = 0;
            if ($urandom_range(0, 1) == 1) rand_txn(m); else drv_req[m] = 1'b0;
          end else begin
            wait_c[m]++;
            if (wait_c[m] > max_wait) max_wait = wait_c[m];
            if ($urandom_range(0, 31) == 0 || wait_c[m] > 100) drv_req[m] = 1'b0;
          end
        end else if ($urandom_range(0, 9) < 4) begin
          rand_txn(m);
          wait_c[m] = 0;
        end
      end
    end
    drv_req[0] = 1'b0; drv_req[1] = 1'b0;
    idle(20);
    chk("max_wait_bounded", max_wait <= 100, 1'b1);
    chk("drain_m0", exp_rsp0.size(), 0);
    chk("drain_m1", exp_rsp1.size(), 0);
    chk("drain_mem", exp_mem.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one data-memory/IO port between two requesters: m0 (core LSU path) and m1 (debug/loader port that preloads or inspects memory and IO registers).
- Round-robin arbitration with a registered request towards memory and a variable-latency memory ack.
- Produces a stall for the core while its access is pending.
- Sits between the core's load/store path and the memory/IO-mapped peripheral block.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; byte-enable width is DATA_W/8
- TIMEOUT, 16, max BUSY cycles before forced error response (used only with ARB_TIMEOUT_EN)

Ports:
- clk_i  in  1  clock, all logic on rising edge
- rst_i  in  1  synchronous active-high reset
- mX_req_i  in  1  access request; X in {0,1}
- mX_we_i  in  1  1 = write
- mX_addr_i  in  ADDR_W  byte address
- mX_wdata_i  in  DATA_W  write data
- mX_be_i  in  DATA_W/8  byte enables
- mX_gnt_o  out  1  request accepted this cycle (combinational)
- mX_rvalid_o  out  1  one-cycle response pulse
- mX_rdata_o  out  DATA_W  read data, valid with rvalid
- mX_err_o  out  1  error response, valid with rvalid
- core_stall_o  out  1  m0_req_i && !m0_rvalid_o
- mem_req_o  out  1  memory request, held until ack
- mem_we_o  out  1  registered write enable
- mem_addr_o  out  ADDR_W  registered address
- mem_wdata_o  out  DATA_W  registered write data
- mem_be_o  out  DATA_W/8  registered byte enables
- mem_ack_i  in  1  memory done; rdata valid same cycle
- mem_rdata_i  in  DATA_W  memory read data

Behaviour:
- Reset (synchronous, rst_i=1 at a clock edge):
  - state=IDLE; all registered outputs 0.
  - RR pointer = "m1 last", so m0 wins the first tie.
- States:
  - IDLE: at most one grant per cycle.
    - Only one request present: grant it.
    - Both present: grant the one not granted last.
    - Grant means mX_gnt_o=1 combinationally in that cycle. At the edge, latch we/addr/wdata/be of the winner into the mem_* registers, record the owner, update the RR pointer, go to BUSY.
  - BUSY: mem_req_o=1, mem_* fields stable; no grants.
    - On mem_ack_i=1: capture mem_rdata_i (reads) or 0 (writes), pulse owner rvalid next cycle with err=0, drop mem_req_o, return to IDLE.
- Latency: req/gnt in cycle 0; mem_req_o in cycle 1; if ack in cycle 1, rvalid in cycle 2. Minimum is 2 cycles; no upper bound without the feature.
- Back-to-back: the next grant may occur in the same cycle as the previous rvalid. Sustained throughput is one access per 2 cycles with zero-wait memory.
- Requester rules:
  - Hold req and all fields stable until gnt.
  - Fields may change after gnt.
  - Dropping req before gnt is allowed; no access results.
- Writes also return an rvalid pulse, with rdata=0.
- mem_ack_i in IDLE is ignored.
- Addresses pass through unchanged; no alignment checking.
- Reset mid-BUSY: transaction abandoned. mem_req_o=0 the cycle after reset; no rvalid is issued for it.
- rdata/err outputs hold their last value when rvalid=0; only rvalid-qualified use is legal.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined:
  - Counter clears on entry to BUSY and increments each BUSY cycle without ack.
  - When it reaches TIMEOUT: mem_req_o drops, owner gets rvalid with err=1 and rdata=32'hDEADBEEF, state returns to IDLE.
  - An ack in the same cycle as the timeout wins (normal response).
- Undefined: no counter; BUSY waits indefinitely; mX_err_o tied 0.

Decomposition:
- Package arb_pkg:
  - arb_state_e {ARB_IDLE, ARB_BUSY}
  - arb_owner_e {OWN_M0, OWN_M1}
  - TIMEOUT_RDATA = 32'hDEADBEEF
- Sub-module rr_pick2: two-request round-robin select.
  - Inputs: req0, req1, last_owner.
  - Outputs: gnt0, gnt1.
  - Purely combinational; the pointer register stays in mem_arbiter.

Test Plan:
- m0-only read:
  - Stimulus: m0 read addr 0x100; mem acks after 3 BUSY cycles with 0x12345678.
  - Expected: gnt in cycle 0; mem_req_o cycles 1-3; m0_rvalid in cycle 4 with rdata=0x12345678, err=0; core_stall_o=1 for cycles 0-3.
- Simultaneous requests after reset:
  - Stimulus: m0 and m1 both request after reset; zero-wait memory.
  - Expected: m0 granted first, m1 granted in cycle 2.
  - Repeat the tie: m1 and m0 alternate.
- m1 write:
  - Stimulus: m1 write addr 0x7000, wdata 0xA5, be 4'b0001.
  - Expected: mem_we_o=1, mem_be_o=4'b0001, fields stable through ack; m1_rvalid with rdata=0.
- Reset mid-BUSY:
  - Stimulus: assert rst_i for 1 cycle while BUSY.
  - Expected: mem_req_o=0 next cycle; no rvalid; next m0 request serviced normally.
- Timeout (ARB_TIMEOUT_EN):
  - Stimulus: no ack.
  - Expected: after 16 BUSY cycles, rvalid with err=1, rdata=0xDEADBEEF.
  - Ack on cycle 16: normal data response, err=0.
- Request withdrawn before grant:
  - Stimulus: m1 raises req while m0 is BUSY, then drops it before IDLE.
  - Expected: no m1 gnt, no mem access.
